rca32_operand_loader: RTL and testbench
=======================================

# rca32_operand_loader

Upstream feeder for the 32-bit ripple-carry adder benchmark (`top`, ports `cin`, `a0..a31`, `b0..b31`). It accepts a byte-wide valid/ready stream, assembles a carry-in and two 32-bit operands from one framed packet, and presents them as a registered, stable operand set under an `op_valid`/`op_ready` handshake. The adder consumes this set combinationally. The block decouples a narrow, bursty source from the wide adder inputs and detects framing errors.

## Interface
- `DATA_W`, 32: operand width; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: stream beat width. `BEATS = DATA_W/BYTE_W` (4).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  source beat valid.
- `in_ready`  out  1  loader accepts a beat.
- `in_sof`  in  1  marks the header beat of a frame.
- `in_data`  in  BYTE_W  beat payload.
- `op_valid`  out  1  operand set complete and stable.
- `op_ready`  in  1  consumer takes the operand set.
- `op_cin`  out  1  carry-in to the adder `cin`.
- `op_a`  out  DATA_W  to adder `a0..a31`.
- `op_b`  out  DATA_W  to adder `b0..b31`.
- `err_pulse`  out  1  one-cycle framing-error flag.

## Operation
- Frame format: 1 header beat (`in_sof`=1, `in_data[0]`=cin, other header bits ignored), then `BEATS` beats of a, LSB byte first, then `BEATS` beats of b, LSB byte first. A frame is 1+2·`BEATS` = 9 beats.
- A beat is accepted when `in_valid && in_ready`.
- FSM states: HDR, LD_A, LD_B, HOLD. Beat counter `bcnt` is $clog2(`BEATS`) bits wide.
- HDR:
  - `in_ready`=1.
  - An accepted beat with `in_sof`=1 latches `op_cin`, clears `bcnt`, and moves to LD_A.
  - An accepted beat with `in_sof`=0 is dropped, pulses `err_pulse`, and stays in HDR.
- LD_A / LD_B:
  - `in_ready`=1.
  - An accepted beat writes byte lane `bcnt` of `op_a` / `op_b`, then increments `bcnt`.
  - When `bcnt`=`BEATS`-1, `bcnt` wraps to 0 and the FSM advances (LD_A→LD_B, LD_B→HOLD).
- Mid-frame SOF: an accepted beat with `in_sof`=1 in LD_A or LD_B:
  - pulses `err_pulse`;
  - is treated as a new header (latches cin, `bcnt`=0, goes to LD_A).
  - Partially loaded bytes are not cleared; they are overwritten by the new frame.
- HOLD:
  - `op_valid`=1 and `in_ready`=0.
  - `op_a`, `op_b`, `op_cin` are held constant.
  - `op_ready`=1 completes the transfer; next state is HDR.
- `op_valid` is a pure decode of the HOLD state. `in_ready` is a pure decode of state and is forced to 0 while `rst_n`=0.
- Outside HOLD, `op_a`/`op_b` may change and are don't-care to the consumer.

## Timing
- Reset values:
  - state HDR, `bcnt`=0;
  - `op_a`=0, `op_b`=0, `op_cin`=0;
  - `op_valid`=0, `err_pulse`=0.
  - `in_ready` rises combinationally once `rst_n` deasserts.
- Latency: `op_valid` goes high on the edge that accepts the last b beat. Data is visible in the same cycle the valid is seen.
- The HOLD→HDR transition occurs on the edge where `op_valid && op_ready`. `in_ready` is 1 in the following cycle.
- Maximum throughput: one operand set every 10 cycles (9 beats + 1 handoff cycle).
- `err_pulse` is registered and high for exactly the cycle after the offending beat.
- Reset asserted mid-frame or in HOLD:
  - all state is cleared immediately (asynchronously);
  - the partial frame is lost and no `err_pulse` is raised.
- `in_valid` low stalls loading indefinitely. No timeout.

## Structure
- Package `rca_loader_pkg` holds:
  - the state enum (HDR, LD_A, LD_B, HOLD);
  - the `BEATS` derivation;
  - the header bit index constant `HDR_CIN_BIT`=0.
- One sub-module is natural: `byte_lane_reg`, a DATA_W register with a byte-lane write enable selected by `bcnt`. It is instantiated twice (a, b).
- The adder itself is not instantiated here. Top-level integration wires `op_*` to `cin/a*/b*`.

## Test plan
- Single frame: header 0x00, a bytes 01 00 00 00, b bytes FF FF FF FF.
  - Expect `op_a`=0x00000001, `op_b`=0xFFFFFFFF, `op_cin`=0.
  - Expect `op_valid` high on the 9th-beat edge; adder s32..s0 = 0x1_00000000.
- Backpressure: complete a frame with cin=1 and hold `op_ready`=0 for 20 cycles.
  - Expect `op_valid`, `op_a`, `op_b`, `op_cin` constant and `in_ready`=0 throughout.
  - Release: HDR on the next cycle.
- Stray beat: beat 0x55 with `in_sof`=0 in HDR.
  - Expect it dropped, one `err_pulse`, state still HDR.
  - A following valid frame loads correctly.
- Mid-frame SOF: header, 2 a-bytes, then a new header (cin=1), then a full valid payload.
  - Expect one `err_pulse` and `op_a`/`op_b` equal to the second frame's payload with `op_cin`=1.
- Reset in LD_B: drop `rst_n` after the 6th beat.
  - Expect all outputs 0 and state HDR.
  - The next full frame loads cleanly.
- Back-to-back: 100 random frames with `op_ready`=1 and `in_valid`=1 continuously.
  - Expect exactly one op transfer per 10 cycles.
  - Each transfer matches the scoreboard; the adder sum matches a+b+cin mod 2^33.

Source files
------------

// File: rtl/rca32_operand_loader_pkg.sv
// Shared types and constants for the byte-stream to adder-operand loader.
package rca_loader_pkg;
  localparam int DATA_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int BEATS       = DATA_W / BYTE_W;
  localparam int HDR_CIN_BIT = 0;

  // Counter width that stays legal when a frame has a single beat per operand.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {HDR, LD_A, LD_B, HOLD} ld_state_e;
endpackage

// File: rtl/rca32_operand_loader_if.sv
// Byte stream in, registered operand set out; master = source/consumer, slave = loader.
interface rca32_operand_loader_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [BYTE_W-1:0] in_data;
  logic              op_valid;
  logic              op_ready;
  logic              op_cin;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              err_pulse;

  modport master (
    output in_valid, in_sof, in_data, op_ready,
    input  in_ready, op_valid, op_cin, op_a, op_b, err_pulse
  );
  modport slave (
    input  in_valid, in_sof, in_data, op_ready,
    output in_ready, op_valid, op_cin, op_a, op_b, err_pulse
  );
endinterface

// File: rtl/rca32_operand_loader_byte_lane_reg.sv
// DATA_W register written one byte lane at a time; lane picked by sel.
module byte_lane_reg
  import rca_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  localparam int NLANE = DATA_W / BYTE_W,
  localparam int SEL_W = cnt_w(NLANE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SEL_W-1:0]  sel,
  input  logic [BYTE_W-1:0] din,
  output logic [DATA_W-1:0] q
);
  logic [NLANE-1:0][BYTE_W-1:0] lanes;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         lanes[i] <= '0;
      else if (we && (sel == SEL_W'(i)))  lanes[i] <= din;
    end
  end

  assign q = lanes;
endmodule

// File: rtl/rca32_operand_loader.sv
// Assembles {cin, a, b} from a 9-beat framed byte stream and holds it for the adder.
module rca32_operand_loader
  import rca_loader_pkg::*;
#(
  parameter int DATA_W = rca_loader_pkg::DATA_W,
  parameter int BYTE_W = rca_loader_pkg::BYTE_W,
  localparam int NBEAT = DATA_W / BYTE_W,
  localparam int CNT_W = cnt_w(NBEAT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rca32_operand_loader_if.slave bus
);
  if (DATA_W % BYTE_W != 0) begin : g_bad_w
    $error("DATA_W must be a multiple of BYTE_W");
  end

  ld_state_e  state, state_nxt;
  logic [CNT_W-1:0] bcnt, bcnt_nxt;
  logic rdy_dec, in_rdy, acc;
  logic cin_ld, a_we, b_we, err_nxt;
  logic cin_q, err_q;

  // in_ready is a pure decode, masked by reset so nothing is taken while held.
  assign rdy_dec = (state != HOLD);
  assign in_rdy  = rst_n & rdy_dec;
  assign acc     = bus.in_valid & in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
      bcnt  <= '0;
      cin_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      err_q <= err_nxt;
      if (cin_ld) cin_q <= bus.in_data[HDR_CIN_BIT];
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    cin_ld    = 1'b0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      HDR: if (acc) begin
        if (bus.in_sof) begin
          cin_ld    = 1'b1;
          bcnt_nxt  = '0;
          state_nxt = LD_A;
        end else begin
          err_nxt   = 1'b1;
        end
      end
      LD_A, LD_B: if (acc) begin
        // A header mid-frame restarts the frame; stale bytes are overwritten later.
        if (bus.in_sof) begin
          err_nxt   = 1'b1;
          cin_ld    = 1'b1;
          bcnt_nxt  = '0;
          state_nxt = LD_A;
        end else begin
          a_we = (state == LD_A);
          b_we = (state == LD_B);
          if (bcnt == CNT_W'(NBEAT-1)) begin
            bcnt_nxt  = '0;
            state_nxt = (state == LD_A) ? LD_B : HOLD;
          end else begin
            bcnt_nxt  = bcnt + 1'b1;
          end
        end
      end
      HOLD: if (bus.op_ready) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end

  byte_lane_reg #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .sel(bcnt), .din(bus.in_data), .q(bus.op_a)
  );
  byte_lane_reg #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .sel(bcnt), .din(bus.in_data), .q(bus.op_b)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.op_valid  = (state == HOLD);
  assign bus.op_cin    = cin_q;
  assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_rca32_operand_loader.sv
// Directed checks of the operand loader plus a back-to-back random frame run.
module tb_rca32_operand_loader;
  localparam int DW = 32;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  rca32_operand_loader_if #(.DATA_W(DW), .BYTE_W(BW)) bus ();

  rca32_operand_loader #(.DATA_W(DW), .BYTE_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] adder_sum();
    return 64'({1'b0, bus.op_a} + {1'b0, bus.op_b} + 33'(bus.op_cin));
  endfunction

  // Present one beat and wait until it is accepted; leaves in_valid asserted.
  task automatic send_beat(input logic sof, input logic [BW-1:0] d);
    logic ok;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_bytes(input logic [DW-1:0] v, input int first, input int last);
    for (int i = first; i <= last; i++) send_beat(1'b0, v[i*BW +: BW]);
  endtask

  task automatic send_frame(input logic cin, input logic [DW-1:0] a, input logic [DW-1:0] b);
    send_beat(1'b1, {7'h00, cin});
    send_bytes(a, 0, 3);
    send_bytes(b, 0, 3);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_ops(input string tag, input logic cin, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    chk({tag, "_valid"}, 64'(bus.op_valid), 64'd1);
    chk({tag, "_a"},     64'(bus.op_a), 64'(a));
    chk({tag, "_b"},     64'(bus.op_b), 64'(b));
    chk({tag, "_cin"},   64'(bus.op_cin), 64'(cin));
  endtask

  task automatic release_op();
    bus.op_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.op_ready = 1'b0;
    chk("rel_valid", 64'(bus.op_valid), 64'd0);
    chk("rel_ready", 64'(bus.in_ready), 64'd1);
  endtask

  logic [DW+DW:0] sb[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a0, b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    bus.op_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_valid", 64'(bus.op_valid), 64'd0);
    chk("rst_a", 64'(bus.op_a), 64'd0);
    chk("rst_b", 64'(bus.op_b), 64'd0);
    chk("rst_cin", 64'(bus.op_cin), 64'd0);
    chk("rst_err", 64'(bus.err_pulse), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single frame; op_valid only on the 9th beat's edge
    send_beat(1'b1, 8'h00);
    send_bytes(32'h00000001, 0, 3);
    send_bytes(32'hFFFFFFFF, 0, 2);
    chk("t1_pre_valid", 64'(bus.op_valid), 64'd0);
    send_beat(1'b0, 8'hFF);
    bus.in_valid = 1'b0;
    chk_ops("t1", 1'b0, 32'h00000001, 32'hFFFFFFFF);
    chk("t1_sum", adder_sum(), 64'h1_0000_0000);
    chk("t1_hold_ready", 64'(bus.in_ready), 64'd0);
    release_op();

    // Backpressure with cin=1
    send_frame(1'b1, 32'h12345678, 32'h9ABCDEF0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk_ops("bp", 1'b1, 32'h12345678, 32'h9ABCDEF0);
      chk("bp_ready", 64'(bus.in_ready), 64'd0);
    end
    chk("bp_sum", adder_sum(), 64'h0_ACF1_3569);
    release_op();

    // Stray non-SOF beat in HDR
    send_beat(1'b0, 8'h55);
    bus.in_valid = 1'b0;
    chk("stray_err", 64'(bus.err_pulse), 64'd1);
    @(posedge clk);
    #1;
    chk("stray_err_off", 64'(bus.err_pulse), 64'd0);
    chk("stray_ready", 64'(bus.in_ready), 64'd1);
    chk("stray_valid", 64'(bus.op_valid), 64'd0);
    send_frame(1'b0, 32'hA5A5_0F0F, 32'h0000_0003);
    chk_ops("stray_nxt", 1'b0, 32'hA5A5_0F0F, 32'h0000_0003);
    release_op();

    // Mid-frame SOF after two a-bytes
    send_beat(1'b1, 8'h00);
    send_bytes(32'h0000_EEDD, 0, 1);
    chk("mid_err_pre", 64'(bus.err_pulse), 64'd0);
    send_beat(1'b1, 8'h01);
    chk("mid_err", 64'(bus.err_pulse), 64'd1);
    send_beat(1'b0, 8'h44);
    chk("mid_err_off", 64'(bus.err_pulse), 64'd0);
    send_bytes(32'h11223344, 1, 3);
    send_bytes(32'h55667788, 0, 3);
    bus.in_valid = 1'b0;
    chk_ops("mid", 1'b1, 32'h11223344, 32'h55667788);
    chk("mid_err_end", 64'(bus.err_pulse), 64'd0);
    release_op();

    // Reset after 6th beat (in LD_B)
    send_beat(1'b1, 8'h01);
    send_bytes(32'hDEADBEEF, 0, 3);
    send_beat(1'b0, 8'h77);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("lrst_a", 64'(bus.op_a), 64'd0);
    chk("lrst_b", 64'(bus.op_b), 64'd0);
    chk("lrst_cin", 64'(bus.op_cin), 64'd0);
    chk("lrst_valid", 64'(bus.op_valid), 64'd0);
    chk("lrst_err", 64'(bus.err_pulse), 64'd0);
    chk("lrst_ready", 64'(bus.in_ready), 64'd0);
    #10;
    rst_n = 1'b1;
    #1;
    chk("lrst_rel_ready", 64'(bus.in_ready), 64'd1);
    chk("lrst_rel_err", 64'(bus.err_pulse), 64'd0);
    @(posedge clk);
    #1;
    send_frame(1'b0, 32'h0BAD_F00D, 32'hCAFE_0001);
    chk_ops("lrst_nxt", 1'b0, 32'h0BAD_F00D, 32'hCAFE_0001);
    release_op();

    // Back-to-back random frames, one transfer every 10 cycles
    bus.op_ready = 1'b1;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          logic c;
          c  = 1'($urandom);
          a0 = $urandom;
          b0 = $urandom;
          sb.push_back({c, a0, b0});
          send_beat(1'b1, {7'h00, c});
          send_bytes(a0, 0, 3);
          send_bytes(b0, 0, 3);
        end
        bus.in_valid = 1'b0;
      end
      begin
        int last_cyc;
        logic [DW+DW:0] e;
        logic got;
        last_cyc = -1;
        for (int f = 0; f < 100; f++) begin
          got = 1'b0;
          for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = bus.op_valid;
          end
          if (!got) begin
            chk("b2b_timeout", 64'd0, 64'd1);
            break;
          end
          e = (sb.size() > 0) ? sb.pop_front() : '0;
          chk_ops("b2b", e[2*DW], e[2*DW-1:DW], e[DW-1:0]);
          chk("b2b_sum", adder_sum(),
              64'({1'b0, e[2*DW-1:DW]} + {1'b0, e[DW-1:0]} + 33'(e[2*DW])));
          if (last_cyc >= 0) chk("b2b_period", 64'(cyc - last_cyc), 64'd10);
          last_cyc = cyc;
        end
      end
    join
    bus.op_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
